// File: rtl/wb_uart_tx_slave_pkg.sv
// Shared definitions for the Wishbone UART transmit slave: register offsets,
// TX state encodings and STATUS bit layout.
package wb_uart_tx_slave_pkg;

  localparam logic UART_REG_TXDATA = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_CNT_LSB = 3;
  localparam int STAT_CNT_MSB = 7;

  // STATUS has a 5-bit count field; deeper FIFOs clamp at 31.
  function automatic logic [4:0] sat_count5(input logic [31:0] n);
    return (n > 32'd31) ? 5'd31 : n[4:0];
  endfunction

endpackage

// File: rtl/wb_uart_tx_slave_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pointers wrap modulo DEPTH.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  import wb_uart_tx_slave_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_uart_tx_slave.sv
// Wishbone classic slave that queues TXDATA byte writes and serialises them
// as 8N1 frames; ack stalls while the FIFO is full.
module wb_uart_tx_slave #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_we_i,
  input  logic [3:0]  wishbone_sel_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_cyc_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o,
  output logic        uart_tx_o
);
  import wb_uart_tx_slave_pkg::*;

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             baud_done;
  logic             tx_d;
  logic             pop;

  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [7:0]       fifo_rdata;

  logic             req;
  logic             sel_status;
  logic             tx_write;
  logic             accept;
  logic             push;
  logic [31:0]      status_word;
  logic             unused_inputs;

  assign unused_inputs = ^{wishbone_addr_i[31:3], wishbone_addr_i[1:0],
                           wishbone_data_i[31:8], wishbone_sel_i[3:1]};

  // A full FIFO only holds off data-carrying TXDATA writes; everything else acks.
  assign req        = wishbone_stb_i && wishbone_cyc_i && !wishbone_ack_o;
  assign sel_status = (wishbone_addr_i[2] == UART_REG_STATUS);
  assign tx_write   = wishbone_we_i && !sel_status && wishbone_sel_i[0];
  assign accept     = req && (!tx_write || !fifo_full);
  assign push       = accept && tx_write;

  always_comb begin
    status_word                             = '0;
    status_word[STAT_FULL]                  = fifo_full;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_BUSY]                  = (state_q != ST_IDLE);
    status_word[STAT_CNT_MSB:STAT_CNT_LSB]  = sat_count5(32'(fifo_count));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wishbone_ack_o  <= 1'b0;
      wishbone_data_o <= '0;
    end else begin
      wishbone_ack_o <= accept;
      if (accept && !wishbone_we_i)
        wishbone_data_o <= sel_status ? status_word : '0;
    end
  end

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wishbone_data_i[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_done = (baud_cnt_q == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_START;
      ST_START: if (baud_done) state_d = ST_DATA;
      ST_DATA:  if (baud_done && bit_idx_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (baud_done) state_d = fifo_empty ? ST_IDLE : ST_START;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    pop  = 1'b0;
    case (state_q)
      ST_IDLE:  pop  = !fifo_empty;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      ST_STOP:  pop  = baud_done && !fifo_empty;
    endcase
  end

  // The line is registered, so it trails the state register by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx_o  <= 1'b1;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      uart_tx_o <= tx_d;
      if (state_d != state_q || state_q == ST_IDLE || baud_done)
        baud_cnt_q <= '0;
      else
        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
      if (state_q == ST_START && baud_done)
        bit_idx_q <= '0;
      else if (state_q == ST_DATA && baud_done)
        bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)
      shift_q <= fifo_rdata;
    else if (state_q == ST_DATA && baud_done)
      shift_q <= {1'b0, shift_q[7:1]};
  end

endmodule
